// File: rtl/mem_wait_pkg.sv
// Shared types and helpers for the picorv32 wait-state memory slave.
// Stall modes, FSM states, request bundle and the xorshift32 step.
package mem_wait_pkg;

    localparam int STALL_NONE  = 0;
    localparam int STALL_RAND  = 1;
    localparam int STALL_FIXED = 2;

    localparam logic [31:0] CON_DEFAULT_ADDR = 32'h1000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/con_fifo.sv
// Synchronous FIFO with occupancy output for the console byte stream.
// Simultaneous push and pop is accepted even when full.
module con_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/mem_wait_slave.sv
// picorv32 native-bus RAM + console slave with configurable wait states.
// Out-of-range accesses are acked with DEADBEEF reads and an err pulse.
module mem_wait_slave
    import mem_wait_pkg::*;
#(
    parameter int          MEM_BYTES  = 4194304,
    parameter logic [31:0] CON_ADDR   = CON_DEFAULT_ADDR,
    parameter int          STALL_MODE = 1,
    parameter int          RAND_BITS  = 1,
    parameter int          FIXED_LAT  = 2,
    parameter logic [31:0] SEED       = 32'd314159265,
    parameter int          CON_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        err
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WAW   = (AW > 2) ? AW - 2 : 1;
    localparam int WORDS = 2 ** WAW;
    localparam int OW    = $clog2(CON_DEPTH) + 1;

    state_t          state;
    state_t          next;
    req_t            req;
    logic [7:0]      cnt;
    logic [31:0]     x32;
    logic            grant;
    logic            latch;
    logic            ack;
    logic            is_con;
    logic            is_wr;
    logic            in_ram;
    logic [WAW-1:0]  widx;
    logic [31:0]     rd_word;
    logic [31:0]     ram [WORDS];
    logic            fifo_full;
    logic            fifo_empty;
    logic [OW-1:0]   fifo_count;
    logic            unused;

    assign unused = mem_instr;

    always_comb begin
        is_wr  = |req.wstrb;
        is_con = (req.addr == CON_ADDR);
        in_ram = !is_con && (req.addr < 32'(MEM_BYTES));
        widx   = WAW'(req.addr[AW-1:0] >> 2);
    end

    always_comb begin
        grant = 1'b1;
        if (STALL_MODE == STALL_RAND) begin
            grant = &x32[RAND_BITS-1:0];
        end else if (STALL_MODE == STALL_FIXED) begin
            grant = (cnt == 8'd0);
        end
        // a console write must find room before it can be acked
        if (is_con && is_wr && fifo_full) grant = 1'b0;
    end

    always_comb begin
        next  = state;
        latch = 1'b0;
        ack   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_valid) begin
                    next  = WAIT;
                    latch = 1'b1;
                end
            end
            WAIT: begin
                if (grant) begin
                    next = ACK;
                    ack  = 1'b1;
                end
            end
            ACK:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        rd_word = 32'hDEAD_BEEF;
        if (is_con)      rd_word = 32'(fifo_count);
        else if (in_ram) rd_word = ram[widx];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            req       <= '0;
            cnt       <= '0;
            x32       <= SEED;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            err       <= 1'b0;
        end else begin
            state     <= next;
            x32       <= xorshift32(x32);
            mem_ready <= ack;
            err       <= ack && !in_ram && !is_con;
            if (latch) begin
                req <= '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
                cnt <= 8'(FIXED_LAT);
            end else if (state == WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (ack) mem_rdata <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (ack && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (req.wstrb[i]) ram[widx][8*i +: 8] <= req.wdata[8*i +: 8];
            end
        end
    end

    con_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (ack && is_con && is_wr),
        .push_data (req.wdata[7:0]),
        .pop       (con_ready),
        .head      (con_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign con_valid = !fifo_empty;

endmodule

// File: tb/tb_mem_wait_slave.sv
// Bench for mem_wait_slave: three instances cover no-stall, random and
// fixed wait modes against a behavioural model of the bus and console.
module tb_mem_wait_slave;

    localparam logic [31:0] CON  = 32'h1000_0000;
    localparam logic [31:0] SEED = 32'd314159265;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst;
    logic [2:0]        valid;
    logic [2:0]        ready;
    logic [2:0]        err;
    logic [2:0]        cvalid;
    logic [2:0]        crdy;
    logic [2:0][31:0]  addr;
    logic [2:0][31:0]  wdata;
    logic [2:0][31:0]  rdata;
    logic [2:0][3:0]   wstrb;
    logic [2:0][7:0]   cdata;

    int errors = 0;
    int checks = 0;

    mem_wait_slave #(
        .STALL_MODE (0),
        .CON_DEPTH  (4)
    ) u0 (
        .clk (clk), .resetn (rst[0]), .mem_valid (valid[0]),
        .mem_instr (1'b0), .mem_addr (addr[0]), .mem_wdata (wdata[0]),
        .mem_wstrb (wstrb[0]), .mem_ready (ready[0]),
        .mem_rdata (rdata[0]), .con_data (cdata[0]),
        .con_valid (cvalid[0]), .con_ready (crdy[0]), .err (err[0])
    );

    mem_wait_slave #(
        .MEM_BYTES  (4096),
        .STALL_MODE (1),
        .RAND_BITS  (1)
    ) u1 (
        .clk (clk), .resetn (rst[1]), .mem_valid (valid[1]),
        .mem_instr (1'b0), .mem_addr (addr[1]), .mem_wdata (wdata[1]),
        .mem_wstrb (wstrb[1]), .mem_ready (ready[1]),
        .mem_rdata (rdata[1]), .con_data (cdata[1]),
        .con_valid (cvalid[1]), .con_ready (crdy[1]), .err (err[1])
    );

    mem_wait_slave #(
        .MEM_BYTES  (4096),
        .STALL_MODE (2),
        .FIXED_LAT  (5)
    ) u2 (
        .clk (clk), .resetn (rst[2]), .mem_valid (valid[2]),
        .mem_instr (1'b0), .mem_addr (addr[2]), .mem_wdata (wdata[2]),
        .mem_wstrb (wstrb[2]), .mem_ready (ready[2]),
        .mem_rdata (rdata[2]), .con_data (cdata[2]),
        .con_valid (cvalid[2]), .con_ready (crdy[2]), .err (err[2])
    );

    function automatic logic [31:0] xs(input logic [31:0] v);
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    // one bus transaction; lat counts cycles from valid rise to ready
    task automatic xact(input int i, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] rd, output int lat,
                        output logic ef);
        @(negedge clk);
        valid[i] = 1'b1;
        addr[i]  = a;
        wdata[i] = wd;
        wstrb[i] = ws;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready[i] && lat < 200);
        rd = rdata[i];
        ef = err[i];
        valid[i] = 1'b0;
        wstrb[i] = 4'h0;
    endtask

    task automatic test_reset();
        rst   = 3'b000;
        valid = 3'b000;
        crdy  = 3'b000;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ready[i], err[i], cvalid[i]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got %b want 000",
                         i, {ready[i], err[i], cvalid[i]});
            end
            checks++;
            if (rdata[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata[%0d]: got %h want 0", i, rdata[i]);
            end
        end
        rst = 3'b111;
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        int          lat;
        logic        ef;
        xact(0, 32'h100, 32'h0, 4'hF, rd, lat, ef);
        xact(0, 32'h100, 32'h1234_5678, 4'b0101, rd, lat, ef);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL m0_write_lat: got %0d want 2", lat);
        end
        xact(0, 32'h100, 32'h0, 4'h0, rd, lat, ef);
        checks++;
        if (rd !== 32'h0034_0078) begin
            errors++;
            $display("FAIL m0_strobe_read: got %h want 00340078", rd);
        end
        checks++;
        if (lat !== 2 || ef !== 1'b0) begin
            errors++;
            $display("FAIL m0_read_lat_err: got lat=%0d err=%b want 2 0",
                     lat, ef);
        end
    endtask

    task automatic test_ram_random();
        logic [31:0] model [64];
        logic [31:0] rd;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          lat;
        int          idx;
        logic        ef;
        for (int k = 0; k < 64; k++) begin
            model[k] = $urandom;
            xact(0, 32'h1000 + 32'(4 * k), model[k], 4'hF, rd, lat, ef);
        end
        for (int n = 0; n < 80; n++) begin
            idx = $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                ws = 4'($urandom_range(1, 15));
                for (int b = 0; b < 4; b++)
                    if (ws[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                xact(0, 32'h1000 + 32'(4 * idx), wd, ws, rd, lat, ef);
            end else begin
                xact(0, 32'h1000 + 32'(4 * idx), 32'h0, 4'h0, rd, lat, ef);
                checks++;
                if (rd !== model[idx]) begin
                    errors++;
                    $display("FAIL rand_read[%0d]: got %h want %h",
                             idx, rd, model[idx]);
                end
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL rand_lat: got %0d want 2", lat);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        int          lat;
        logic        ef;
        xact(0, 32'h0, 32'hCAFE_F00D, 4'hF, rd, lat, ef);
        xact(0, 32'h0040_0000, 32'h5555_5555, 4'hF, rd, lat, ef);
        checks++;
        if (ef !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_err: got %b want 1", ef);
        end
        @(negedge clk);
        checks++;
        if (err[0] !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_pulse: got %b want 0", err[0]);
        end
        xact(0, 32'h0, 32'h0, 4'h0, rd, lat, ef);
        checks++;
        if (rd !== 32'hCAFE_F00D || ef !== 1'b0) begin
            errors++;
            $display("FAIL oor_ram_kept: got %h err=%b want cafef00d 0",
                     rd, ef);
        end
        xact(0, 32'h0040_0000, 32'h0, 4'h0, rd, lat, ef);
        checks++;
        if (rd !== 32'hDEAD_BEEF || ef !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: got %h err=%b want deadbeef 1", rd, ef);
        end
    endtask

    task automatic test_console();
        logic [7:0]  msg [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        logic [7:0]  got [5];
        logic [31:0] rd;
        int          lat;
        int          n;
        logic        ef;
        crdy[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            xact(0, CON, {24'h0, msg[k]}, 4'b0001, rd, lat, ef);
            checks++;
            if (lat !== 2 || ef !== 1'b0) begin
                errors++;
                $display("FAIL con_push[%0d]: got lat=%0d err=%b want 2 0",
                         k, lat, ef);
            end
        end
        xact(0, CON, 32'h0, 4'h0, rd, lat, ef);
        checks++;
        if (rd !== 32'd4) begin
            errors++;
            $display("FAIL con_occupancy: got %0d want 4", rd);
        end
        checks++;
        if (cvalid[0] !== 1'b1 || cdata[0] !== 8'h41) begin
            errors++;
            $display("FAIL con_head: got v=%b d=%h want 1 41",
                     cvalid[0], cdata[0]);
        end
        n = 0;
        fork
            xact(0, CON, {24'h0, msg[4]}, 4'b0001, rd, lat, ef);
            begin
                repeat (20) @(negedge clk);
                crdy[0] = 1'b1;
                for (int c = 0; c < 100 && n < 5; c++) begin
                    if (cvalid[0]) begin
                        got[n] = cdata[0];
                        n++;
                    end
                    @(negedge clk);
                end
            end
        join
        crdy[0] = 1'b0;
        checks++;
        if (lat < 18 || lat >= 200) begin
            errors++;
            $display("FAIL con_full_stall: got lat=%0d want 18..199", lat);
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL con_drain_count: got %0d want 5", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got[k] !== msg[k]) begin
                errors++;
                $display("FAIL con_order[%0d]: got %h want %h",
                         k, got[k], msg[k]);
            end
        end
        xact(0, CON, 32'h0, 4'h0, rd, lat, ef);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL con_empty: got %0d want 0", rd);
        end
    endtask

    task automatic test_fixed();
        logic [31:0] rd;
        int          lat;
        logic        ef;
        xact(2, 32'h10, 32'h0, 4'h0, rd, lat, ef);
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL fixed_lat: got %0d want 7", lat);
        end
        @(negedge clk);
        checks++;
        if (ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL fixed_one_cycle: got %b want 0", ready[2]);
        end
    endtask

    // edge t after release sees x32 = xs^t(SEED); a request sampled at
    // edge s is granted at the first later edge whose x32 has bit 0 set,
    // and the next request is sampled two edges after that grant
    task automatic test_random();
        logic [31:0] x;
        int          s;
        int          acks;
        logic        expect_rdy;
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        addr[1]  = 32'h0;
        wstrb[1] = 4'h0;
        valid[1] = 1'b1;
        rst[1]   = 1'b1;
        x = SEED;
        s = 0;
        acks = 0;
        for (int t = 0; t < 20000 && acks < 1000; t++) begin
            expect_rdy = (t > s) && x[0];
            if (expect_rdy) begin
                s = t + 2;
                acks++;
            end
            x = xs(x);
            @(negedge clk);
            checks++;
            if (ready[1] !== expect_rdy) begin
                errors++;
                $display("FAIL rand_ack[%0d]: got %b want %b",
                         t, ready[1], expect_rdy);
            end
        end
        valid[1] = 1'b0;
        checks++;
        if (acks !== 1000) begin
            errors++;
            $display("FAIL rand_count: got %0d want 1000", acks);
        end
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] rd;
        int          lat;
        logic        ef;
        logic        seen;
        crdy[2] = 1'b0;
        xact(2, 32'h200, 32'h1111_1111, 4'hF, rd, lat, ef);
        xact(2, CON, 32'h5A, 4'b0001, rd, lat, ef);
        xact(2, 32'h200, 32'h0, 4'h0, rd, lat, ef);
        checks++;
        if (rd !== 32'h1111_1111 || cvalid[2] !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got %h v=%b want 11111111 1",
                     rd, cvalid[2]);
        end
        @(negedge clk);
        addr[2]  = 32'h200;
        wdata[2] = 32'hAAAA_AAAA;
        wstrb[2] = 4'hF;
        valid[2] = 1'b1;
        repeat (3) @(negedge clk);
        rst[2]   = 1'b0;
        valid[2] = 1'b0;
        #1;
        checks++;
        if ({ready[2], err[2], cvalid[2]} !== 3'b000 || rdata[2] !== 32'h0) begin
            errors++;
            $display("FAIL mid_async_reset: got rdy/err/cv=%b rdata=%h want 000 0",
                     {ready[2], err[2], cvalid[2]}, rdata[2]);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ready[2]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_ack: got ack=%b want 0", seen);
        end
        rst[2] = 1'b1;
        xact(2, 32'h200, 32'h0, 4'h0, rd, lat, ef);
        checks++;
        if (rd !== 32'h1111_1111) begin
            errors++;
            $display("FAIL mid_ram_kept: got %h want 11111111", rd);
        end
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_ram_random();
        test_out_of_range();
        test_console();
        test_fixed();
        test_random();
        test_reset_midwrite();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wait_slave.md
# mem_wait_slave

Synthesizable memory slave for the picorv32 native memory interface, used as the RAM and console model in simulation and FPGA bring-up benches. It holds byte-addressable RAM with write strobes and a console MMIO register draining into a byte FIFO. It adds configurable wait-state insertion (none, pseudo-random, fixed) and out-of-range error reporting. It sits directly on the core's `mem_*` port; the console stream feeds a UART or `$write` sink.

## Interface
- `MEM_BYTES`, 4194304 — RAM size in bytes; power of two, at least 4.
- `CON_ADDR`, 32'h1000_0000 — console register address; word-aligned.
- `STALL_MODE`, 1 — 0: no wait states; 1: xorshift random; 2: fixed latency.
- `RAND_BITS`, 1 — random mode acks when `x32[RAND_BITS-1:0]` is all ones; 1 gives 50 %.
- `FIXED_LAT`, 2 — wait cycles in fixed mode; range 0..255.
- `SEED`, 314159265 — xorshift32 reset value; must be non-zero.
- `CON_DEPTH`, 16 — console FIFO entries; power of two.

Ports:
- `clk` in 1 — clock.
- `resetn` in 1 — reset, asynchronous, active-low.
- `mem_valid` in 1 — request valid.
- `mem_instr` in 1 — instruction fetch; informational only.
- `mem_addr` in 32 — byte address; word-aligned for fetches.
- `mem_wdata` in 32 — write data.
- `mem_wstrb` in 4 — byte write enables; 0 means read.
- `mem_ready` out 1 — one-cycle acknowledge; registered.
- `mem_rdata` out 32 — read data; registered and valid only while `mem_ready` is high.
- `con_data` out 8 — FIFO head byte.
- `con_valid` out 1 — FIFO not empty.
- `con_ready` in 1 — sink accepts the head byte.
- `err` out 1 — one-cycle pulse on an out-of-range access.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE + `mem_valid` → WAIT. The request is latched; the wait counter is loaded with `FIXED_LAT`.
- WAIT → ACK when the grant is true.
  - Mode 0: grant is always true.
  - Mode 1: grant is the random condition.
  - Mode 2: grant is counter == 0. The counter decrements each WAIT cycle.
  - Console writes additionally require the FIFO to be not full.
- ACK: `mem_ready`=1 for exactly one cycle, then → IDLE.
  - The write commits at the ACK edge, per byte lane.
  - The read fetches the word at `mem_addr & ~3` with lanes in little-endian order.
- `x32` advances every cycle out of reset, using shifts 13, 17, 5.
- Console write, when any strobe is set: push `mem_wdata[7:0]`. RAM is untouched.
- Console read: returns `{24'h0, occupancy}`, with occupancy zero-extended.
- Address ≥ `MEM_BYTES` and ≠ `CON_ADDR`: the access is still acked.
  - Writes are dropped.
  - Reads return 32'hDEAD_BEEF.
  - `err` pulses in the ACK cycle.
- RAM arithmetic: the index is `mem_addr[log2(MEM_BYTES)-1:0]`; the upper bits only drive the range check. There is no wrap on lane+1..3, because the address is aligned.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `err`=0, `con_valid`=0, FSM=IDLE, `x32`=`SEED`, FIFO empty. RAM contents are not reset.
- Latency from the `mem_valid` rise to `mem_ready`:
  - Mode 0: 2 cycles.
  - Mode 2: `FIXED_LAT`+2 cycles.
  - Mode 1: at least 2 cycles.
- Request fields are captured at IDLE→WAIT. Changes to them while pending are ignored.
- `mem_valid` high in the cycle after ACK starts a new request; there is no re-ack of the old one.
- FIFO push and pop may occur in the same cycle. This is legal when full, and occupancy is unchanged.
- The FIFO pops on `con_valid && con_ready`.
- Reset asserted mid-transaction: the FSM goes to IDLE at once, and a pending write is lost.

## Structure
- `mem_wait_pkg`:
  - STALL_* mode constants.
  - FSM state enum.
  - `xorshift32` function.
  - `CON_DEFAULT_ADDR`.
- Sub-module `con_fifo`: synchronous FIFO with parametrised width and depth, and an occupancy output. The top instantiates one.

## Test plan
- Mode 0, write 32'h1234_5678 with strobe 4'b0101 to 0x100, then read 0x100 → 32'h0034_0078 on a RAM initially zeroed by the bench; each ack arrives 2 cycles after valid.
- Mode 2, `FIXED_LAT`=5, read → `mem_ready` exactly 7 cycles after the `mem_valid` rise, high for one cycle only.
- Mode 1, default seed, 1000 back-to-back reads → every ack is one cycle; the ack-cycle pattern matches the reference xorshift model.
- `CON_DEPTH`=4, `con_ready`=0, write "ABCDE" to `CON_ADDR` → the fifth write stalls; a console read (which completes without FIFO stall) returns 4. Raising `con_ready` drains A..D in order, then E is acked and output.
- Write to 0x0040_0000 (`MEM_BYTES` default) → `err` pulses and RAM is unchanged; a read there returns 32'hDEAD_BEEF.
- Assert `resetn` low during WAIT of a write → no ack, RAM unchanged, all outputs at their reset values asynchronously.
